axi4_delay_link: RTL and testbench
==================================

# axi4_delay_link

Parametrised multi-channel AXI4 link-delay buffer for the simulation harness, sitting between the host-driven ctrl/cpu_managed/fpga_managed/mem AXI4 bundles and FPGATop. It generalises the fixed single-register pre/post-clock skew into per-sub-channel elastic FIFOs with a programmable minimum transit latency and full valid/ready backpressure. NUM_CHANNELS independent AXI4 links share one clock domain.

## Interface
- ID_BITS, default 4: AXI ID width.
- ADDR_BITS, default 64: address width.
- DATA_BITS, default 64: data width; STRB_BITS = DATA_BITS/8, derived.
- NUM_CHANNELS, default 4: independent AXI4 links.
- DEPTH, default 4: entries per sub-channel FIFO; power of two, ≥2.
- LATENCY, default 1: minimum cycles from input handshake to output valid; range 1..15.
- Payload widths: AX_W = ADDR_BITS+ID_BITS+11 (addr, id, size[2:0], len[7:0]); W_W = DATA_BITS+STRB_BITS+1; R_W = ID_BITS+DATA_BITS+3; B_W = ID_BITS+2.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high; clears all state.
- s_aw_valid, s_ar_valid, s_w_valid  in  NUM_CHANNELS each  manager-side request valids.
- s_aw_ready, s_ar_ready, s_w_ready  out  NUM_CHANNELS each  manager-side request readies.
- s_aw_bits, s_ar_bits / s_w_bits  in  NUM_CHANNELS*AX_W / NUM_CHANNELS*W_W  request payloads, channel c at slice c.
- s_r_valid, s_b_valid  out  NUM_CHANNELS each; s_r_ready, s_b_ready  in  NUM_CHANNELS each.
- s_r_bits / s_b_bits  out  NUM_CHANNELS*R_W / NUM_CHANNELS*B_W  response payloads.
- m_aw/m_ar/m_w _valid, _bits  out; _ready  in  mirror of s_ request side toward subordinate.
- m_r/m_b _valid, _bits  in; _ready  out  mirror of s_ response side.
- idle  out  1  high when every FIFO in every channel is empty.

## Operation
- Each channel holds five independent FIFOs: AW, W, AR (s→m) and R, B (m→s). No cross-sub-channel ordering imposed; AXI ordering preserved within each FIFO.
- Enqueue when in_valid && in_ready; in_ready = !full (registered-state based, no combinational path from out_ready).
- Each slot has a saturating age counter (4 bits): set to 1 on enqueue, +1 per cycle while occupied, saturates at LATENCY.
- out_valid = !empty && age[head] ≥ LATENCY; out_bits = data[head]. Dequeue on out_valid && out_ready.
- Simultaneous enqueue and dequeue on a full FIFO: enqueue refused (ready already low); on empty FIFO: enqueue accepted, no dequeue (valid low).
- Pointers are log2(DEPTH)+1 bits; full/empty from MSB compare; wrap silently.
- Payload bits pass unmodified; no width conversion, no burst splitting.
- idle is registered-state combinational: AND of all empty flags.

## Timing
- Reset values: all *_ready outputs 0 during reset, 1 the cycle after release (FIFOs empty); all *_valid outputs 0; idle 1; bits outputs 0.
- Latency: handshake in cycle t → out_valid first high in cycle t+LATENCY, if out side idle.
- Throughput: one beat/cycle per FIFO sustained once pipeline filled, provided DEPTH ≥ LATENCY+1; with DEPTH ≤ LATENCY throughput is DEPTH/(LATENCY+1) per FIFO (documented, not an error).
- Backpressure: out_valid held with stable bits until accepted; age continues saturating, never wraps.
- Reset asserted mid-burst: all in-flight beats discarded asynchronously; valids drop immediately.

## Structure
- Package axi4_delay_pkg: width-derivation functions (ax_w, w_w, r_w, b_w) and age counter width constant.
- One sub-module: delay_fifo (WIDTH, DEPTH, LATENCY params; storage, pointers, per-slot age). Top instantiates 5×NUM_CHANNELS via generate and slices payload vectors.

## Test plan
- Reset: hold reset 3 cycles, sample → all valids 0, all readies 0 during reset, readies 1 and idle 1 first cycle after release.
- Latency: LATENCY=3, single AW beat addr=0x1000 on channel 2 at cycle 10, m_aw_ready=1 → m_aw_valid rises cycle 13 with identical bits, other channels silent.
- Full/backpressure: DEPTH=4, m_w_ready=0, push 6 W beats → s_w_ready low after 4th; release ready → beats 1..4 emerge in order, then 5..6 accepted.
- Streaming: LATENCY=1, DEPTH=4, 100 back-to-back R beats with s_r_ready=1 → 100 beats out, one per cycle, order and data exact.
- Independence: stall B on channel 0 while AR flows on channel 0 and all sub-channels of channel 1 → only channel-0 B blocks; idle low until B drained.
- Mid-operation reset: 3 beats in flight in AR FIFO, pulse reset asynchronously → m_ar_valid drops immediately, no stale beat emerges after release, idle 1.

Source files
------------

// File: rtl/axi4_delay_pkg.sv
// ---------------------------------------------------------------------------
// axi4_delay_pkg
// Shared definitions for the AXI4 link-delay buffer: payload width
// derivation for each AXI sub-channel and the width of the per-slot age
// counters that enforce the minimum transit latency.
// ---------------------------------------------------------------------------
package axi4_delay_pkg;

    // Age counters saturate at LATENCY, which is limited to 1..15.
    localparam int AGE_W = 4;

    // AW/AR payload: addr, id, size[2:0], len[7:0]
    function automatic int ax_w(input int addr_bits, input int id_bits);
        return addr_bits + id_bits + 11;
    endfunction

    // W payload: data, strb, last
    function automatic int w_w(input int data_bits);
        return data_bits + data_bits / 8 + 1;
    endfunction

    // R payload: id, data, resp[1:0], last
    function automatic int r_w(input int id_bits, input int data_bits);
        return id_bits + data_bits + 3;
    endfunction

    // B payload: id, resp[1:0]
    function automatic int b_w(input int id_bits);
        return id_bits + 2;
    endfunction

endpackage

// File: rtl/delay_fifo.sv
// ---------------------------------------------------------------------------
// delay_fifo
// Elastic FIFO with a minimum transit latency. Every slot carries a
// saturating age counter; the head beat is only presented once it has been
// resident for LATENCY cycles.
// Ports:
//   clock, reset         clock, async active-high reset
//   i_in_valid/o_in_ready/i_in_bits     enqueue side
//   o_out_valid/i_out_ready/o_out_bits  dequeue side
//   o_empty              FIFO holds no beats
// ---------------------------------------------------------------------------
module delay_fifo
    import axi4_delay_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_bits,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_bits,
    output logic             o_empty
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [AGE_W-1:0]   AGE_SAT = AGE_W'(LATENCY);
    localparam logic [AGE_W-1:0]   AGE_ONE = AGE_W'(1);
    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0]                r_wptr, r_rptr;
    logic [DEPTH-1:0][WIDTH-1:0]   r_data;
    logic [DEPTH-1:0][AGE_W-1:0]   r_age;

    logic [PTR_W-1:0] w_widx, w_ridx;
    logic             w_full, w_empty, w_push, w_pop;

    assign w_widx  = r_wptr[PTR_W-1:0];
    assign w_ridx  = r_rptr[PTR_W-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) && (w_widx == w_ridx);

    // Ready is forced low while reset is held so nothing is accepted into
    // a FIFO that is being cleared.
    assign o_in_ready  = !w_full && !reset;
    assign o_out_valid = !w_empty && (r_age[w_ridx] >= AGE_SAT);
    assign o_out_bits  = r_data[w_ridx];
    assign o_empty     = w_empty;

    assign w_push = i_in_valid && o_in_ready;
    assign w_pop  = o_out_valid && i_out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_data <= '0;
            r_age  <= '0;
        end else begin
            // Free slots age too; harmless because an enqueue reloads the
            // counter, and it keeps the update free of occupancy decode.
            for (int i = 0; i < DEPTH; i++) begin
                if (r_age[i] < AGE_SAT) r_age[i] <= r_age[i] + AGE_ONE;
            end
            // A push never targets the head while it is occupied (full
            // blocks it), so it cannot disturb the beat being presented.
            if (w_push) begin
                r_data[w_widx] <= i_in_bits;
                r_age[w_widx]  <= AGE_ONE;
                r_wptr         <= r_wptr + PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/axi4_delay_link.sv
// ---------------------------------------------------------------------------
// axi4_delay_link
// Multi-channel AXI4 link-delay buffer. Each of NUM_CHANNELS links gets five
// independent delay FIFOs (AW, W, AR toward the subordinate; R, B back to
// the manager), each enforcing a minimum LATENCY with full backpressure.
// Ports:
//   clock, reset                    clock, async active-high reset
//   s_{aw,ar,w}_{valid,ready,bits}  manager-side requests (in)
//   m_{aw,ar,w}_{valid,ready,bits}  subordinate-side requests (out)
//   m_{r,b}_{valid,ready,bits}      subordinate-side responses (in)
//   s_{r,b}_{valid,ready,bits}      manager-side responses (out)
//   idle                            every FIFO of every channel empty
// Channel c occupies slice [c*W +: W] of each payload vector.
// ---------------------------------------------------------------------------
module axi4_delay_link
    import axi4_delay_pkg::*;
#(
    parameter int ID_BITS      = 4,
    parameter int ADDR_BITS    = 64,
    parameter int DATA_BITS    = 64,
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 4,
    parameter int LATENCY      = 1,
    localparam int AX_W = ax_w(ADDR_BITS, ID_BITS),
    localparam int W_W  = w_w(DATA_BITS),
    localparam int R_W  = r_w(ID_BITS, DATA_BITS),
    localparam int B_W  = b_w(ID_BITS),
    localparam int NC   = NUM_CHANNELS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NC-1:0]     s_aw_valid,
    output logic [NC-1:0]     s_aw_ready,
    input  logic [NC*AX_W-1:0] s_aw_bits,
    input  logic [NC-1:0]     s_ar_valid,
    output logic [NC-1:0]     s_ar_ready,
    input  logic [NC*AX_W-1:0] s_ar_bits,
    input  logic [NC-1:0]     s_w_valid,
    output logic [NC-1:0]     s_w_ready,
    input  logic [NC*W_W-1:0] s_w_bits,
    output logic [NC-1:0]     s_r_valid,
    input  logic [NC-1:0]     s_r_ready,
    output logic [NC*R_W-1:0] s_r_bits,
    output logic [NC-1:0]     s_b_valid,
    input  logic [NC-1:0]     s_b_ready,
    output logic [NC*B_W-1:0] s_b_bits,
    output logic [NC-1:0]     m_aw_valid,
    input  logic [NC-1:0]     m_aw_ready,
    output logic [NC*AX_W-1:0] m_aw_bits,
    output logic [NC-1:0]     m_ar_valid,
    input  logic [NC-1:0]     m_ar_ready,
    output logic [NC*AX_W-1:0] m_ar_bits,
    output logic [NC-1:0]     m_w_valid,
    input  logic [NC-1:0]     m_w_ready,
    output logic [NC*W_W-1:0] m_w_bits,
    input  logic [NC-1:0]     m_r_valid,
    output logic [NC-1:0]     m_r_ready,
    input  logic [NC*R_W-1:0] m_r_bits,
    input  logic [NC-1:0]     m_b_valid,
    output logic [NC-1:0]     m_b_ready,
    input  logic [NC*B_W-1:0] m_b_bits,
    output logic              idle
);

    // One empty flag per sub-channel: [0]=AW [1]=W [2]=AR [3]=R [4]=B
    logic [NC-1:0][4:0] w_empty;

    for (genvar c = 0; c < NC; c++) begin : g_ch
        delay_fifo #(.WIDTH(AX_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) u_aw (
            .clock, .reset,
            .i_in_valid (s_aw_valid[c]), .o_in_ready (s_aw_ready[c]),
            .i_in_bits  (s_aw_bits[c*AX_W +: AX_W]),
            .o_out_valid(m_aw_valid[c]), .i_out_ready(m_aw_ready[c]),
            .o_out_bits (m_aw_bits[c*AX_W +: AX_W]), .o_empty(w_empty[c][0]));

        delay_fifo #(.WIDTH(W_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) u_w (
            .clock, .reset,
            .i_in_valid (s_w_valid[c]), .o_in_ready (s_w_ready[c]),
            .i_in_bits  (s_w_bits[c*W_W +: W_W]),
            .o_out_valid(m_w_valid[c]), .i_out_ready(m_w_ready[c]),
            .o_out_bits (m_w_bits[c*W_W +: W_W]), .o_empty(w_empty[c][1]));

        delay_fifo #(.WIDTH(AX_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) u_ar (
            .clock, .reset,
            .i_in_valid (s_ar_valid[c]), .o_in_ready (s_ar_ready[c]),
            .i_in_bits  (s_ar_bits[c*AX_W +: AX_W]),
            .o_out_valid(m_ar_valid[c]), .i_out_ready(m_ar_ready[c]),
            .o_out_bits (m_ar_bits[c*AX_W +: AX_W]), .o_empty(w_empty[c][2]));

        delay_fifo #(.WIDTH(R_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) u_r (
            .clock, .reset,
            .i_in_valid (m_r_valid[c]), .o_in_ready (m_r_ready[c]),
            .i_in_bits  (m_r_bits[c*R_W +: R_W]),
            .o_out_valid(s_r_valid[c]), .i_out_ready(s_r_ready[c]),
            .o_out_bits (s_r_bits[c*R_W +: R_W]), .o_empty(w_empty[c][3]));

        delay_fifo #(.WIDTH(B_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) u_b (
            .clock, .reset,
            .i_in_valid (m_b_valid[c]), .o_in_ready (m_b_ready[c]),
            .i_in_bits  (m_b_bits[c*B_W +: B_W]),
            .o_out_valid(s_b_valid[c]), .i_out_ready(s_b_ready[c]),
            .o_out_bits (s_b_bits[c*B_W +: B_W]), .o_empty(w_empty[c][4]));
    end

    assign idle = &w_empty;

endmodule

// File: tb/tb_axi4_delay_link.sv
module tb_axi4_delay_link;
    import axi4_delay_pkg::*;

    localparam int IDB = 4, AB = 64, DB = 64, NC = 4, DEP = 4, LAT = 3;
    localparam int AX_W = ax_w(AB, IDB);
    localparam int W_W  = w_w(DB);
    localparam int R_W  = r_w(IDB, DB);
    localparam int B_W  = b_w(IDB);
    localparam int NF   = NC * 5;   // flat FIFO index f = ch*5 + {aw,w,ar,r,b}

    typedef logic [127:0] d_t;
    typedef struct { d_t d; int t; } ent_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [NC-1:0] s_aw_valid, s_aw_ready, s_ar_valid, s_ar_ready, s_w_valid, s_w_ready;
    logic [NC-1:0] s_r_valid, s_r_ready, s_b_valid, s_b_ready;
    logic [NC-1:0] m_aw_valid, m_aw_ready, m_ar_valid, m_ar_ready, m_w_valid, m_w_ready;
    logic [NC-1:0] m_r_valid, m_r_ready, m_b_valid, m_b_ready;
    logic [NC*AX_W-1:0] s_aw_bits, s_ar_bits, m_aw_bits, m_ar_bits;
    logic [NC*W_W-1:0]  s_w_bits, m_w_bits;
    logic [NC*R_W-1:0]  s_r_bits, m_r_bits;
    logic [NC*B_W-1:0]  s_b_bits, m_b_bits;
    logic idle;

    axi4_delay_link #(.ID_BITS(IDB), .ADDR_BITS(AB), .DATA_BITS(DB),
                      .NUM_CHANNELS(NC), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_bits(s_aw_bits),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits(s_ar_bits),
        .s_w_valid(s_w_valid),   .s_w_ready(s_w_ready),   .s_w_bits(s_w_bits),
        .s_r_valid(s_r_valid),   .s_r_ready(s_r_ready),   .s_r_bits(s_r_bits),
        .s_b_valid(s_b_valid),   .s_b_ready(s_b_ready),   .s_b_bits(s_b_bits),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits(m_aw_bits),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits(m_ar_bits),
        .m_w_valid(m_w_valid),   .m_w_ready(m_w_ready),   .m_w_bits(m_w_bits),
        .m_r_valid(m_r_valid),   .m_r_ready(m_r_ready),   .m_r_bits(m_r_bits),
        .m_b_valid(m_b_valid),   .m_b_ready(m_b_ready),   .m_b_bits(m_b_bits),
        .idle(idle));

    // Flat per-FIFO stimulus and observation views
    logic [NF-1:0]         tb_in_v, tb_out_r, ob_v, ob_rdy;
    logic [NF-1:0][127:0]  tb_in_d, ob_d;

    always_comb begin
        s_aw_valid = '0; s_aw_bits = '0; m_aw_ready = '0;
        s_w_valid  = '0; s_w_bits  = '0; m_w_ready  = '0;
        s_ar_valid = '0; s_ar_bits = '0; m_ar_ready = '0;
        m_r_valid  = '0; m_r_bits  = '0; s_r_ready  = '0;
        m_b_valid  = '0; m_b_bits  = '0; s_b_ready  = '0;
        for (int c = 0; c < NC; c++) begin
            s_aw_valid[c] = tb_in_v[c*5+0]; s_aw_bits[c*AX_W +: AX_W] = tb_in_d[c*5+0][AX_W-1:0]; m_aw_ready[c] = tb_out_r[c*5+0];
            s_w_valid[c]  = tb_in_v[c*5+1]; s_w_bits[c*W_W +: W_W]    = tb_in_d[c*5+1][W_W-1:0];  m_w_ready[c]  = tb_out_r[c*5+1];
            s_ar_valid[c] = tb_in_v[c*5+2]; s_ar_bits[c*AX_W +: AX_W] = tb_in_d[c*5+2][AX_W-1:0]; m_ar_ready[c] = tb_out_r[c*5+2];
            m_r_valid[c]  = tb_in_v[c*5+3]; m_r_bits[c*R_W +: R_W]    = tb_in_d[c*5+3][R_W-1:0];  s_r_ready[c]  = tb_out_r[c*5+3];
            m_b_valid[c]  = tb_in_v[c*5+4]; m_b_bits[c*B_W +: B_W]    = tb_in_d[c*5+4][B_W-1:0];  s_b_ready[c]  = tb_out_r[c*5+4];
        end
    end

    always_comb begin
        ob_v = '0; ob_rdy = '0; ob_d = '0;
        for (int c = 0; c < NC; c++) begin
            ob_v[c*5+0] = m_aw_valid[c]; ob_rdy[c*5+0] = s_aw_ready[c]; ob_d[c*5+0][AX_W-1:0] = m_aw_bits[c*AX_W +: AX_W];
            ob_v[c*5+1] = m_w_valid[c];  ob_rdy[c*5+1] = s_w_ready[c];  ob_d[c*5+1][W_W-1:0]  = m_w_bits[c*W_W +: W_W];
            ob_v[c*5+2] = m_ar_valid[c]; ob_rdy[c*5+2] = s_ar_ready[c]; ob_d[c*5+2][AX_W-1:0] = m_ar_bits[c*AX_W +: AX_W];
            ob_v[c*5+3] = s_r_valid[c];  ob_rdy[c*5+3] = m_r_ready[c];  ob_d[c*5+3][R_W-1:0]  = s_r_bits[c*R_W +: R_W];
            ob_v[c*5+4] = s_b_valid[c];  ob_rdy[c*5+4] = m_b_ready[c];  ob_d[c*5+4][B_W-1:0]  = s_b_bits[c*B_W +: B_W];
        end
    end

    // Reference model: one queue of (payload, handshake cycle) per FIFO.
    // A beat is visible once LAT cycles have elapsed since its handshake;
    // the FIFO accepts while it holds fewer than DEP beats.
    ent_t  mq [NF][$];
    int    cyc, n_chk, n_pass;
    logic [NF-1:0] hs_in, hs_out;
    string nm [5] = '{"aw", "w", "ar", "r", "b"};

    task automatic chk(input string tag, input d_t obs, input d_t exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic int fw(input int k);
        case (k)
            0, 2:    return AX_W;
            1:       return W_W;
            3:       return R_W;
            default: return B_W;
        endcase
    endfunction

    function automatic d_t rnd(input int f);
        d_t r, m;
        r = {$urandom, $urandom, $urandom, $urandom};
        m = (d_t'(1) << fw(f % 5)) - d_t'(1);
        return r & m;
    endfunction

    function automatic logic m_valid(input int f);
        return mq[f].size() > 0 && (cyc - mq[f][0].t >= LAT);
    endfunction

    // One clock: check every output at negedge, then update the model at
    // posedge with the handshakes the checks implied. Returns at posedge+1.
    task automatic step();
        logic ev, er, all_e;
        @(negedge clock);
        all_e = 1'b1;
        for (int f = 0; f < NF; f++) begin
            if (reset) mq[f].delete();
            ev = !reset && m_valid(f);
            er = !reset && (mq[f].size() < DEP);
            all_e = all_e && (mq[f].size() == 0);
            chk($sformatf("%s%0d_valid", nm[f%5], f/5), d_t'(ob_v[f]), d_t'(ev));
            chk($sformatf("%s%0d_ready", nm[f%5], f/5), d_t'(ob_rdy[f]), d_t'(er));
            if (ev) chk($sformatf("%s%0d_bits", nm[f%5], f/5), ob_d[f], mq[f][0].d);
            hs_in[f]  = tb_in_v[f] && er;
            hs_out[f] = ev && tb_out_r[f];
        end
        chk("idle", d_t'(idle), d_t'(all_e));
        @(posedge clock);
        for (int f = 0; f < NF; f++) begin
            if (hs_out[f]) void'(mq[f].pop_front());
            if (hs_in[f])  mq[f].push_back('{d: tb_in_d[f], t: cyc});
        end
        cyc++;
        #1;
    endtask

    initial begin
        int t0, k, acc, sent, got, first, last;
        d_t lat_bits;
        d_t wb [6];

        reset = 1'b1; tb_in_v = '0; tb_out_r = '0; tb_in_d = '0;
        cyc = 0; n_chk = 0; n_pass = 0; hs_in = '0; hs_out = '0;

        // Reset held 3 cycles: readies/valids low, idle high
        repeat (3) step();
        reset = 1'b0;
        tb_out_r = '1;
        repeat (6) step();

        // Latency: single AW beat on channel 2
        lat_bits = '0;
        lat_bits[AX_W-1:0] = {64'h1000, 4'h3, 3'd3, 8'd0};
        tb_in_v[10] = 1'b1; tb_in_d[10] = lat_bits; t0 = cyc;
        step();
        tb_in_v[10] = 1'b0;
        k = 0;
        while (!m_aw_valid[2] && k < 20) begin step(); k++; end
        chk("aw_latency", d_t'(cyc - t0), d_t'(LAT));
        chk("aw_lat_bits", d_t'(m_aw_bits[2*AX_W +: AX_W]), lat_bits);
        chk("aw_other_ch", d_t'(m_aw_valid & 4'b1011), '0);
        repeat (3) step();

        // Full / backpressure on channel 0 W
        for (int i = 0; i < 6; i++) wb[i] = rnd(1);
        tb_out_r[1] = 1'b0; acc = 0;
        for (int i = 0; i < 10; i++) begin
            tb_in_v[1] = (acc < 6); tb_in_d[1] = wb[acc < 6 ? acc : 5];
            step();
            if (hs_in[1]) acc++;
        end
        chk("w_full_acc", d_t'(acc), d_t'(4));
        chk("w_full_rdy", d_t'(s_w_ready[0]), '0);
        tb_out_r[1] = 1'b1;
        for (int i = 0; i < 40 && !(acc == 6 && mq[1].size() == 0); i++) begin
            tb_in_v[1] = (acc < 6); tb_in_d[1] = wb[acc < 6 ? acc : 5];
            step();
            if (hs_in[1]) acc++;
        end
        tb_in_v[1] = 1'b0;
        chk("w_full_done", d_t'(acc), d_t'(6));
        repeat (3) step();

        // Streaming: 100 R beats on channel 1, one per cycle out
        sent = 0; got = 0; first = 0; last = 0;
        for (int i = 0; i < 200 && got < 100; i++) begin
            tb_in_v[8] = (sent < 100); tb_in_d[8] = rnd(8);
            step();
            if (hs_in[8]) sent++;
            if (hs_out[8]) begin
                if (got == 0) first = cyc;
                last = cyc; got++;
            end
        end
        tb_in_v[8] = 1'b0;
        chk("r_stream_cnt", d_t'(got), d_t'(100));
        chk("r_stream_rate", d_t'(last - first), d_t'(99));

        // Independence: ch0 B stalled, ch0 AR and all of ch1 flowing
        tb_out_r[4] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tb_in_v[4] = 1'b1; tb_in_d[4] = rnd(4);
            tb_in_v[2] = $urandom_range(0, 1) == 1; tb_in_d[2] = rnd(2);
            for (int f = 5; f < 10; f++) begin
                tb_in_v[f] = $urandom_range(0, 1) == 1; tb_in_d[f] = rnd(f);
            end
            step();
        end
        tb_in_v = '0;
        repeat (2 * LAT + 2) step();
        chk("b0_blocked", d_t'(m_b_ready[0]), '0);
        chk("idle_while_b0", d_t'(idle), '0);
        tb_out_r[4] = 1'b1;
        k = 0;
        while (!idle && k < 40) begin step(); k++; end
        chk("b0_drained_idle", d_t'(idle), d_t'(1));

        // Random traffic on every FIFO
        for (int i = 0; i < 1500; i++) begin
            tb_in_v  = NF'($urandom);
            tb_out_r = NF'($urandom | $urandom);
            for (int f = 0; f < NF; f++) tb_in_d[f] = rnd(f);
            step();
        end
        tb_in_v = '0; tb_out_r = '1;
        repeat (20) step();

        // Mid-operation reset with 3 AR beats in flight on channel 0
        tb_out_r[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tb_in_v[2] = 1'b1; tb_in_d[2] = rnd(2);
            step();
        end
        tb_in_v[2] = 1'b0;
        repeat (LAT + 1) step();
        chk("ar_pre_rst", d_t'(m_ar_valid[0]), d_t'(1));
        #2 reset = 1'b1;
        #1;
        chk("ar_rst_drop", d_t'(m_ar_valid[0]), '0);
        chk("ar_rst_idle", d_t'(idle), d_t'(1));
        repeat (2) step();
        reset = 1'b0;
        tb_out_r = '1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
